// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: assembles WIDTH-bit words from a
// qualified bit stream and holds each one under a valid/ack handshake.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     d,
  input  logic                     d_vld,
  input  logic                     clr,
  output logic [WIDTH-1:0]         word,
  output logic                     word_vld,
  input  logic                     word_ack,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             done;
  logic             room;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_nxt = {sr[WIDTH-2:0], d};
    end else begin : g_lsb
      assign sr_nxt = {d, sr[WIDTH-1:1]};
    end
  endgenerate

  assign done = d_vld && (bit_cnt == LAST);
  // holding register is free if empty or being consumed this edge
  assign room = !word_vld || word_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      word     <= '0;
      word_vld <= 1'b0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else if (clr) begin
      sr       <= '0;
      word     <= '0;
      word_vld <= 1'b0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (d_vld) begin
        sr <= sr_nxt;
        if (done) begin
          bit_cnt <= '0;
          busy    <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          busy    <= 1'b1;
        end
      end
      if (done) begin
        if (room) begin
          word     <= sr_nxt;
          word_vld <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (word_vld && word_ack) begin
        word_vld <= 1'b0;
      end
    end
  end

endmodule
